i2s_sample_fifo: RTL and testbench
==================================

I2S_SAMPLE_FIFO -- requirements
Module: i2s_sample_fifo

Interface
REQ-001 SHALL have parameter FIFO_LEN_BITS, default 4; depth DEPTH = 2**FIFO_LEN_BITS entries.
REQ-002 SHALL have port clk input 1: clock; all logic on its rising edge.
REQ-003 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-004 SHALL have port software_rst input 1: synchronous flush, from CTRL0 bit 0.
REQ-005 SHALL have port in_data input 48: sample; [23:0] left, [47:24] right.
REQ-006 SHALL have port in_valid input 1: push request, single-cycle pulse from the register file.
REQ-007 SHALL have port in_ready output 1: push accepted this cycle; drives the register file's fifo_ready.
REQ-008 SHALL have port out_data output 48: head sample, first-word-fall-through.
REQ-009 SHALL have port out_valid output 1: head valid.
REQ-010 SHALL have port out_ready input 1: pop request from the I2S/DAC consumer.
REQ-011 SHALL have port fifo_threshold input FIFO_LEN_BITS+1: low-watermark.
REQ-012 SHALL have port fifo_level output FIFO_LEN_BITS+1: entry count.
REQ-013 SHALL have ports fifo_full, fifo_empty and fifo_low, each output 1: status flags.
REQ-014 SHALL have port underrun_clr input 1: clear the underrun counter.
REQ-015 SHALL have port underrun_count output 16: saturating underrun counter.

Function
REQ-016 SHALL push when in_valid && in_ready, writing in_data at wr_ptr and incrementing wr_ptr modulo DEPTH.
REQ-017 SHALL drive in_ready = !fifo_full && !software_rst.
REQ-018 SHALL drop in_valid when in_ready=0: no write, no pointer change, no error flag.
REQ-019 SHALL drive out_valid = !fifo_empty and out_data = mem[rd_ptr] combinationally from storage; 0-cycle read latency.
REQ-020 SHALL pop when out_valid && out_ready, incrementing rd_ptr modulo DEPTH.
REQ-021 SHALL leave rd_ptr unchanged when out_ready=1 and the FIFO is empty.
REQ-022 SHALL keep fifo_level as a registered count, FIFO_LEN_BITS+1 bits wide, range 0..DEPTH: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
REQ-023 SHALL make a push while empty visible on out_valid in the next cycle, not in the same cycle.
REQ-024 SHALL allow simultaneous push+pop when full: in_ready=0 blocks the push, the pop proceeds, and the level decrements.
REQ-025 SHALL handle pointer wrap from DEPTH-1 to 0 with no data corruption and no flag glitch.
REQ-026 SHALL derive flags from fifo_level: fifo_full = (level==DEPTH), fifo_empty = (level==0), fifo_low = (level < fifo_threshold).
REQ-027 SHALL compare fifo_low unsigned; threshold 0 gives fifo_low=0 always, and threshold > DEPTH gives fifo_low=1 always.
REQ-028 SHALL, on software_rst=1, zero wr_ptr, rd_ptr and level at the next edge and ignore any push or pop that cycle; storage contents are not cleared.
REQ-029 SHALL count one underrun per cycle with out_ready && fifo_empty && !software_rst, saturating at 16'hFFFF.
REQ-030 SHALL give underrun_clr priority over an increment in the same cycle, clearing the counter to 0.

Reset
REQ-031 SHALL, on rst, zero pointers, level and underrun_count within one edge; outputs are then in_ready=1, out_valid=0, fifo_empty=1, fifo_full=0, fifo_level=0, fifo_low=(fifo_threshold!=0).
REQ-032 SHALL give rst priority over software_rst, and software_rst priority over push and pop.
REQ-033 SHALL, on rst mid-stream, discard all queued samples; storage itself is not reset.

Configuration
REQ-034 SHALL include the underrun counter logic only when macro I2S_FIFO_UNDERRUN_CNT_EN is defined.
REQ-035 SHALL, without I2S_FIFO_UNDERRUN_CNT_EN, keep the underrun_count port present and tied to 0 and ignore underrun_clr; all other behaviour is identical.

Structure
REQ-036 SHALL take from shared package i2s_pkg: I2S_SAMPLE_W=48, I2S_CHAN_W=24, UNDERRUN_CNT_W=16.
REQ-037 SHALL place storage in sub-module i2s_fifo_mem (DEPTH x 48 array, synchronous write, asynchronous read); pointers, level and flags stay in i2s_sample_fifo.

Verification
REQ-038 SHALL cover: after rst, push 0x000002_000001 -> next cycle out_valid=1, out_data=0x000002_000001, level=1, fifo_empty=0.
REQ-039 SHALL cover: 16 pushes with out_ready=0 (FIFO_LEN_BITS=4) -> fifo_full=1, level=16, in_ready=0; a 17th push is dropped and level stays 16.
REQ-040 SHALL cover: full FIFO, in_valid=1 and out_ready=1 for 1 cycle -> pop of sample 0 only, level=15; the next push is accepted and is read out last.
REQ-041 SHALL cover: threshold=4, levels 3/4/5 -> fifo_low=1/0/0; threshold=0 -> fifo_low=0 at level 0.
REQ-042 SHALL cover: 40 pushes and 40 pops interleaved -> out_data sequence equals in_data sequence across 2 pointer wraps.
REQ-043 SHALL cover: with I2S_FIFO_UNDERRUN_CNT_EN, empty FIFO and out_ready=1 for 5 cycles -> underrun_count=5; underrun_clr then gives 0; without the macro the count stays 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared widths and sample types for the I2S sample path.
//   I2S_SAMPLE_W    - packed stereo sample width ({right, left})
//   I2S_CHAN_W      - width of one channel
//   UNDERRUN_CNT_W  - width of the saturating underrun counter
package i2s_pkg;

  localparam int unsigned I2S_SAMPLE_W   = 48;
  localparam int unsigned I2S_CHAN_W     = 24;
  localparam int unsigned UNDERRUN_CNT_W = 16;

  typedef logic [I2S_SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    logic [I2S_CHAN_W-1:0] right;
    logic [I2S_CHAN_W-1:0] left;
  } stereo_t;

endpackage

// File: rtl/i2s_fifo_mem.sv
// i2s_fifo_mem: DEPTH x 48-bit sample storage, synchronous write, asynchronous read.
// Ports:
//   clk   - write clock (rising edge)
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from raddr
// Contents are never reset; validity is tracked by the owner's pointers.
module i2s_fifo_mem
  import i2s_pkg::*;
#(
  parameter int unsigned FIFO_LEN_BITS = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [FIFO_LEN_BITS-1:0] waddr,
  input  sample_t                  wdata,
  input  logic [FIFO_LEN_BITS-1:0] raddr,
  output sample_t                  rdata
);

  localparam int unsigned DEPTH = 2 ** FIFO_LEN_BITS;

  sample_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: first-word-fall-through sample FIFO between the register
// file (producer) and the I2S/DAC consumer.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   software_rst    - synchronous flush (pointers and level to zero)
//   in_data/valid   - push side; in_ready = !fifo_full && !software_rst
//   out_data/valid  - head sample, valid whenever not empty
//   out_ready       - pop request
//   fifo_threshold  - low-watermark; fifo_low = level < threshold
//   fifo_level      - registered entry count 0..DEPTH
//   fifo_full/empty/low - status flags derived from fifo_level
//   underrun_clr    - clears underrun_count
//   underrun_count  - saturating count of pop requests while empty
// Build option: define I2S_FIFO_UNDERRUN_CNT_EN to include the underrun
// counter; otherwise underrun_count is tied to zero and underrun_clr ignored.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned FIFO_LEN_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      software_rst,
  input  logic [I2S_SAMPLE_W-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [I2S_SAMPLE_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic [FIFO_LEN_BITS:0]    fifo_threshold,
  output logic [FIFO_LEN_BITS:0]    fifo_level,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      fifo_low,
  input  logic                      underrun_clr,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
);

  localparam int unsigned DEPTH = 2 ** FIFO_LEN_BITS;
  localparam logic [FIFO_LEN_BITS:0] LEVEL_FULL = (FIFO_LEN_BITS + 1)'(DEPTH);

  logic [FIFO_LEN_BITS-1:0] wr_ptr;
  logic [FIFO_LEN_BITS-1:0] rd_ptr;
  logic [FIFO_LEN_BITS:0]   level;
  logic                     push;
  logic                     pop;

  assign fifo_level = level;
  assign fifo_full  = (level == LEVEL_FULL);
  assign fifo_empty = (level == '0);
  assign fifo_low   = (level < fifo_threshold);

  assign in_ready  = !fifo_full && !software_rst;
  assign out_valid = !fifo_empty;

  assign push = in_valid && in_ready;
  // A flush discards the pop along with everything else that cycle.
  assign pop  = out_valid && out_ready && !software_rst;

  always_ff @(posedge clk) begin
    if (rst || software_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  i2s_fifo_mem #(
    .FIFO_LEN_BITS(FIFO_LEN_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

`ifdef I2S_FIFO_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] underrun_q;

  always_ff @(posedge clk) begin
    if (rst || underrun_clr) begin
      underrun_q <= '0;
    end else if (out_ready && fifo_empty && !software_rst && (underrun_q != '1)) begin
      underrun_q <= underrun_q + 1'b1;
    end
  end

  assign underrun_count = underrun_q;
`else
  logic unused_underrun_clr;

  assign unused_underrun_clr = underrun_clr;
  assign underrun_count      = '0;
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// tb_i2s_sample_fifo: directed and randomized checks of i2s_sample_fifo
// against a queue-based model of the FIFO contents.
module tb_i2s_sample_fifo;

  localparam int unsigned LB    = 4;
  localparam int unsigned DEPTH = 2 ** LB;

  logic          clk = 1'b0;
  logic          rst;
  logic          software_rst;
  logic [47:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [47:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LB:0]   fifo_threshold;
  logic [LB:0]   fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_low;
  logic          underrun_clr;
  logic [15:0]   underrun_count;

  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          checking = 1'b0;

  logic [47:0] q[$];
  int unsigned m_under = 0;

  always #5 clk = ~clk;

  i2s_sample_fifo #(
    .FIFO_LEN_BITS(LB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .software_rst   (software_rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fifo_threshold (fifo_threshold),
    .fifo_level     (fifo_level),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_low       (fifo_low),
    .underrun_clr   (underrun_clr),
    .underrun_count (underrun_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue of samples; everything else follows from its size.
  always @(posedge clk) begin
    int unsigned n;
    n = q.size();
    if (rst) begin
      q.delete();
      m_under = 0;
    end else begin
      if (software_rst) begin
        q.delete();
      end else begin
        if (out_ready && n > 0) void'(q.pop_front());
        if (in_valid && n < DEPTH) q.push_back(in_data);
      end
`ifdef I2S_FIFO_UNDERRUN_CNT_EN
      if (underrun_clr) m_under = 0;
      else if (out_ready && n == 0 && !software_rst && m_under < 65535) m_under++;
`endif
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      int unsigned n;
      n = q.size();
      chk("in_ready",  in_ready,   (n < DEPTH) && !software_rst);
      chk("out_valid", out_valid,  n > 0);
      chk("level",     fifo_level, n);
      chk("full",      fifo_full,  n == DEPTH);
      chk("empty",     fifo_empty, n == 0);
      chk("low",       fifo_low,   n < int'(fifo_threshold));
      chk("underrun",  underrun_count, m_under);
      if (n > 0) chk("out_data", out_data, q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [47:0] x;
    rst = 1'b1; software_rst = 1'b0; in_data = '0; in_valid = 1'b0;
    out_ready = 1'b0; fifo_threshold = 5'd4; underrun_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checking = 1'b1;

    chk("rst_level", fifo_level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_low", fifo_low, 1);
    chk("rst_underrun", underrun_count, 0);

    // First push: visible only after the edge.
    in_data = 48'h000002_000001; in_valid = 1'b1;
    chk("push_same_cycle_out_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("first_out_valid", out_valid, 1);
    chk("first_out_data", out_data, 48'h000002_000001);
    chk("first_level", fifo_level, 1);
    chk("first_empty", fifo_empty, 0);

    software_rst = 1'b1; tick(); software_rst = 1'b0;
    chk("flush_level", fifo_level, 0);

    // Fill to full, then a dropped 17th push.
    for (int i = 0; i < 16; i++) begin
      in_data = {24'(200 + i), 24'(100 + i)}; in_valid = 1'b1;
      tick();
    end
    chk("full_flag", fifo_full, 1);
    chk("full_level", fifo_level, 16);
    chk("full_in_ready", in_ready, 0);
    in_data = 48'hDEAD00_BEEF00;
    tick();
    chk("drop_level", fifo_level, 16);
    chk("drop_head", out_data, {24'd200, 24'd100});

    // Full with push+pop: only the pop happens.
    x = 48'hABCDEF_123456;
    in_data = x; out_ready = 1'b1;
    tick();
    chk("fullpp_level", fifo_level, 15);
    chk("fullpp_head", out_data, {24'd201, 24'd101});
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("refill_level", fifo_level, 16);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("last_level", fifo_level, 1);
    chk("last_data", out_data, x);
    tick();
    out_ready = 1'b0;
    chk("drained_empty", fifo_empty, 1);

    // Low watermark.
    software_rst = 1'b1; tick(); software_rst = 1'b0;
    fifo_threshold = 5'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = 48'(i); tick(); end
    chk("low_lvl3", fifo_low, 1);
    tick();
    chk("low_lvl4", fifo_low, 0);
    tick();
    in_valid = 1'b0;
    chk("low_lvl5", fifo_low, 0);
    fifo_threshold = 5'd0;
    software_rst = 1'b1; tick(); software_rst = 1'b0;
    chk("low_thr0_lvl0", fifo_low, 0);
    fifo_threshold = 5'd17;
    #1;
    chk("low_thr17", fifo_low, 1);
    fifo_threshold = 5'd4;

    // Underrun counting.
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b0;
`ifdef I2S_FIFO_UNDERRUN_CNT_EN
    chk("underrun_5", underrun_count, 5);
`else
    chk("underrun_off", underrun_count, 0);
`endif
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    chk("underrun_clr", underrun_count, 0);

    // 40 interleaved push/pop pairs, wrapping the pointers twice.
    for (int i = 0; i < 40; i++) begin
      in_data = {$urandom, $urandom}; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("interleave_empty", fifo_empty, 1);

    // Random traffic with occasional flushes, clears and threshold changes.
    for (int i = 0; i < 600; i++) begin
      in_data      = {$urandom, $urandom};
      in_valid     = ($urandom_range(0, 99) < 55);
      out_ready    = ($urandom_range(0, 99) < 45);
      software_rst = ($urandom_range(0, 99) == 0);
      underrun_clr = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 19) == 0) fifo_threshold = 5'($urandom_range(0, DEPTH + 2));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; software_rst = 1'b0; underrun_clr = 1'b0;

    // Reset mid-stream discards everything queued.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in_data = 48'(i + 7); tick(); end
    in_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_empty", fifo_empty, 1);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_out_valid", out_valid, 0);
    tick();

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
